ssd_scan_multiplexer: RTL and testbench

Parametrised multiplexed seven-segment display driver: time-multiplexes N_DIGITS active-low cathode patterns onto one shared segment bus and drives one active-low anode per digit.

- Adds three behaviours the fixed 4-digit scan in the game top level lacks:
  - per-digit enable and per-digit blink;
  - a global blink force, used for win/draw flashing;
  - an inter-digit blanking guard against ghosting.
- It sits between the game's SSD pattern logic and the board's An*/Ca..Cg/Dp pins, and replaces the inline DIV_CLK-based scan.

---
 rtl/ssd_scan_multiplexer.sv | 160 ++++++++++++++++
 tb/tb_ssd_scan_multiplexer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_multiplexer.sv
// rtl/ssd_scan_multiplexer.sv - multiplexed seven-segment scan driver with enable, blink and blanking guard
module ssd_scan_multiplexer #(
  parameter int N_DIGITS     = 4,
  parameter int SCAN_DIV     = 18,
  parameter int BLANK_CYCLES = 64,
  parameter int BLINK_DIV    = 25,
  localparam int IDX_W       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [7*N_DIGITS-1:0] i_seg_in,
  input  logic [N_DIGITS-1:0]   i_dp_in,
  input  logic [N_DIGITS-1:0]   i_digit_en,
  input  logic [N_DIGITS-1:0]   i_blink_en,
  input  logic                  i_blink_force,
  output logic [N_DIGITS-1:0]   o_an_n,
  output logic [6:0]            o_seg_n,
  output logic                  o_dp_n,
  output logic [IDX_W-1:0]      o_digit_idx,
  output logic                  o_blink_phase
);

  localparam logic [IDX_W-1:0]    LP_LAST_SLOT = IDX_W'(N_DIGITS - 1);
  localparam logic [SCAN_DIV-1:0] LP_BLANK     = SCAN_DIV'(BLANK_CYCLES);

  logic [SCAN_DIV-1:0]  r_dwell_cnt;
  logic [IDX_W-1:0]     r_slot;
  logic [BLINK_DIV-1:0] r_blink_cnt;
  logic                 r_blink_phase;

  logic [6:0] r_snap_seg;
  logic       r_snap_dp;
  logic       r_snap_en;
  logic       r_snap_blink;

  logic                w_dwell_zero;
  logic                w_dwell_wrap;
  logic                w_blink_wrap;
  logic [6:0]          w_live_seg;
  logic                w_live_dp;
  logic                w_live_en;
  logic                w_live_blink;
  logic [N_DIGITS-1:0] w_an_sel;
  logic [6:0]          w_cur_seg;
  logic                w_cur_dp;
  logic                w_cur_en;
  logic                w_cur_blink;
  logic                w_guard;
  logic                w_blank;
  logic                w_dark;

  assign w_dwell_zero = (r_dwell_cnt == '0);
  assign w_dwell_wrap = &r_dwell_cnt;
  assign w_blink_wrap = &r_blink_cnt;

  // Dwell counter and slot pointer; slot wraps explicitly so odd digit counts never overrun
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dwell_cnt <= '0;
      r_slot      <= '0;
    end else begin
      r_dwell_cnt <= r_dwell_cnt + 1'b1;
      if (w_dwell_wrap) begin
        r_slot <= (r_slot == LP_LAST_SLOT) ? '0 : r_slot + 1'b1;
      end
    end
  end

  // Free-running blink divider; phase flips on each wrap
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
      if (w_blink_wrap) begin
        r_blink_phase <= ~r_blink_phase;
      end
    end
  end

  // Select the current slot's live inputs and its anode pattern
  always_comb begin
    w_live_seg   = 7'h7F;
    w_live_dp    = 1'b0;
    w_live_en    = 1'b0;
    w_live_blink = 1'b0;
    w_an_sel     = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_slot == IDX_W'(i)) begin
        w_live_seg   = i_seg_in[7*i +: 7];
        w_live_dp    = i_dp_in[i];
        w_live_en    = i_digit_en[i];
        w_live_blink = i_blink_en[i];
        w_an_sel[i]  = 1'b0;
      end
    end
  end

  // Latch the slot's digit at the start of its dwell so mid-dwell input changes stay hidden
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_snap_seg   <= '0;
      r_snap_dp    <= 1'b0;
      r_snap_en    <= 1'b0;
      r_snap_blink <= 1'b0;
    end else if (w_dwell_zero) begin
      r_snap_seg   <= w_live_seg;
      r_snap_dp    <= w_live_dp;
      r_snap_en    <= w_live_en;
      r_snap_blink <= w_live_blink;
    end
  end

  // On the first dwell cycle the snapshot still holds the previous digit, so use the values being latched
  assign w_cur_seg   = w_dwell_zero ? w_live_seg   : r_snap_seg;
  assign w_cur_dp    = w_dwell_zero ? w_live_dp    : r_snap_dp;
  assign w_cur_en    = w_dwell_zero ? w_live_en    : r_snap_en;
  assign w_cur_blink = w_dwell_zero ? w_live_blink : r_snap_blink;

  generate
    if (BLANK_CYCLES == 0) begin : g_no_guard
      assign w_guard = 1'b0;
    end else begin : g_guard
      assign w_guard = (r_dwell_cnt < LP_BLANK);
    end
  endgenerate

  assign w_blank = w_guard | ~w_cur_en;
  assign w_dark  = r_blink_phase & (w_cur_blink | i_blink_force);

  // Registered output decode: blank guard first, then blink darkening, else the digit
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_an_n        <= '1;
      o_seg_n       <= 7'h7F;
      o_dp_n        <= 1'b1;
      o_digit_idx   <= '0;
      o_blink_phase <= 1'b0;
    end else begin
      o_digit_idx   <= r_slot;
      o_blink_phase <= r_blink_phase;
      if (w_blank) begin
        o_an_n  <= '1;
        o_seg_n <= 7'h7F;
        o_dp_n  <= 1'b1;
      end else begin
        o_an_n <= w_an_sel;
        if (w_dark) begin
          o_seg_n <= 7'h7F;
          o_dp_n  <= 1'b1;
        end else begin
          o_seg_n <= w_cur_seg;
          o_dp_n  <= ~w_cur_dp;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_multiplexer.sv
// tb/tb_ssd_scan_multiplexer.sv - scoreboard bench for ssd_scan_multiplexer
module tb_ssd_scan_multiplexer;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic       ph;
    int         k;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [27:0] seg_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  blink_en;
  logic        blink_force;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [1:0]  digit_idx;
  logic        blink_phase;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          k = 0;

  logic [27:0] h_seg[0:1023];
  logic [3:0]  h_dp[0:1023];
  logic [3:0]  h_en[0:1023];
  logic [3:0]  h_bl[0:1023];
  logic        h_force[0:1023];

  ssd_scan_multiplexer #(
    .N_DIGITS(4),
    .SCAN_DIV(4),
    .BLANK_CYCLES(2),
    .BLINK_DIV(6)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_seg_in(seg_in),
    .i_dp_in(dp_in),
    .i_digit_en(digit_en),
    .i_blink_en(blink_en),
    .i_blink_force(blink_force),
    .o_an_n(an_n),
    .o_seg_n(seg_n),
    .o_dp_n(dp_n),
    .o_digit_idx(digit_idx),
    .o_blink_phase(blink_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs after the kk-th edge since reset release (kk = 0: reset values).
  // Outputs after edge kk show the state after edge kk-1; the slot's digit was sampled
  // at the edge that began its dwell, blink_force at edge kk itself.
  function automatic exp_t model(int kk);
    exp_t        e;
    int          d, s, p, j0;
    logic [27:0] t;
    logic [6:0]  sg;
    logic        en, bl, dpv, blank, dark;
    e.k = kk;
    if (kk == 0) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.idx = 2'd0; e.ph = 1'b0;
      return e;
    end
    d   = (kk - 1) % 16;
    s   = ((kk - 1) / 16) % 4;
    p   = ((kk - 1) / 64) % 2;
    j0  = kk - d;
    t   = h_seg[j0];
    sg  = t[7*s +: 7];
    en  = h_en[j0][s];
    bl  = h_bl[j0][s];
    dpv = h_dp[j0][s];
    blank = (d < 2) || !en;
    dark  = (p == 1) && (bl || h_force[kk]);
    e.idx = 2'(s);
    e.ph  = 1'(p);
    if (blank) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
    end else begin
      e.an = ~(4'b0001 << s);
      if (dark) begin
        e.seg = 7'h7F; e.dp = 1'b1;
      end else begin
        e.seg = sg; e.dp = ~dpv;
      end
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    k++;
    h_seg[k]   = seg_in;
    h_dp[k]    = dp_in;
    h_en[k]    = digit_en;
    h_bl[k]    = blink_en;
    h_force[k] = blink_force;
    sb_q.push_back(model(k));
  endtask

  task automatic hold_reset();
    @(posedge clk);
    #1;
    sb_q.push_back(model(0));
  endtask

  task automatic run_to(input int kt);
    while (k < kt) step();
  endtask

  // Monitor: pops one expectation per output sample (each negedge, and right after reset rises)
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or posedge reset);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if ({an_n, seg_n, dp_n, digit_idx, blink_phase} !== {e.an, e.seg, e.dp, e.idx, e.ph}) begin
          n_bad++;
          $display("FAIL out k=%0d: got an_n=%h seg_n=%h dp_n=%b idx=%0d ph=%b, want an_n=%h seg_n=%h dp_n=%b idx=%0d ph=%b",
                   e.k, an_n, seg_n, dp_n, digit_idx, blink_phase, e.an, e.seg, e.dp, e.idx, e.ph);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    seg_in      = {7'h24, 7'h30, 7'h12, 7'h4F};
    dp_in       = 4'b0101;
    digit_en    = 4'hF;
    blink_en    = 4'h0;
    blink_force = 1'b0;

    hold_reset();
    hold_reset();
    reset = 1'b0;
    k = 0;

    // basic scan through frame 0, then change digit 0 mid-dwell of frame 1 slot 0
    run_to(69);
    seg_in[6:0] = 7'h00;
    // frame 2: digit 2 disabled
    run_to(128);
    digit_en = 4'b1011;
    // frame 3 onward: digit 0 blinks (phase 1 in frame 3)
    run_to(192);
    digit_en = 4'hF;
    blink_en = 4'b0001;
    // frame 5 (phase 1): force blink from mid-dwell of slot 1
    run_to(341);
    blink_force = 1'b1;
    run_to(384);
    blink_force = 1'b0;
    // reset mid-dwell at dwell 9 of slot 2, checked before any clock edge
    run_to(425);
    @(negedge clk);
    #2;
    sb_q.push_back(model(0));
    reset = 1'b1;
    hold_reset();
    hold_reset();
    reset = 1'b0;
    k = 0;
    run_to(80);

    @(negedge clk);
    #3;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
